// File: rtl/mips_wb_stage_pkg.sv
// Shared MIPS-I opcode/func constants and write-back state encoding.
package mips_wb_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 6;

    localparam logic [OP_W-1:0] OP_R_FORM = 6'h00;
    localparam logic [OP_W-1:0] OP_J      = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL    = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ    = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE    = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI   = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU  = 6'h09;
    localparam logic [OP_W-1:0] OP_SLTI   = 6'h0A;
    localparam logic [OP_W-1:0] OP_SLTIU  = 6'h0B;
    localparam logic [OP_W-1:0] OP_ANDI   = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI    = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI   = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI    = 6'h0F;
    localparam logic [OP_W-1:0] OP_LB     = 6'h20;
    localparam logic [OP_W-1:0] OP_LH     = 6'h21;
    localparam logic [OP_W-1:0] OP_LW     = 6'h23;
    localparam logic [OP_W-1:0] OP_LBU    = 6'h24;
    localparam logic [OP_W-1:0] OP_LHU    = 6'h25;
    localparam logic [OP_W-1:0] OP_SB     = 6'h28;
    localparam logic [OP_W-1:0] OP_SH     = 6'h29;
    localparam logic [OP_W-1:0] OP_SW     = 6'h2B;

    localparam logic [OP_W-1:0] FN_ADD    = 6'h20;
    localparam logic [OP_W-1:0] FN_JR     = 6'h08;
    localparam logic [OP_W-1:0] FN_JALR   = 6'h09;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    // ADDI..LUI occupy the contiguous block 0x08-0x0F
    function automatic logic is_alu_imm(input logic [OP_W-1:0] op);
        return op[5:3] == 3'b001;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Little-endian byte/halfword lane select with sign/zero extension for loads.
module wb_load_align
    import mips_wb_stage_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [1:0]        addr_i,
    input  logic [DATA_W-1:0] word_i,
    output logic [DATA_W-1:0] data_c,
    output logic              misalign_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (addr_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Misaligned halfwords still use the addr[1] lane; LW passes the word through
    always_comb begin
        data_c     = word_i;
        misalign_c = 1'b0;
        case (op_i)
            OP_LB:  data_c = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU: data_c = {24'd0, byte_sel};
            OP_LH: begin
                data_c     = {{16{half_sel[15]}}, half_sel};
                misalign_c = addr_i[0];
            end
            OP_LHU: begin
                data_c     = {16'd0, half_sel};
                misalign_c = addr_i[0];
            end
            OP_LW:  misalign_c = (addr_i != 2'd0);
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_wb_stage.sv
// MIPS write-back stage: destination/source select, load parking and
// register-file write port.
module mips_wb_stage
    import mips_wb_stage_pkg::*;
#(
    parameter int unsigned DW = DATA_W,
    parameter int unsigned RW = REG_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          In_valid,
    output logic          In_ready,
    input  logic [31:0]   In_ins,
    input  logic [DW-1:0] In_alu,
    input  logic [DW-1:0] In_pc4,
    input  logic          Mem_rvalid,
    input  logic [DW-1:0] Mem_rdata,
    output logic          We,
    output logic [RW-1:0] Waddr,
    output logic [DW-1:0] Wdata,
    output logic          Busy,
    output logic          Err,
    output logic [DW-1:0] Ret_cnt
);

    logic [OP_W-1:0] ins_op;
    logic [OP_W-1:0] ins_func;
    logic [RW-1:0]   ins_rt;
    logic [RW-1:0]   ins_rd;
    logic            unused_ins_bits;

    assign ins_op          = In_ins[31:26];
    assign ins_func        = In_ins[5:0];
    assign ins_rt          = RW'(In_ins[20:16]);
    assign ins_rd          = RW'(In_ins[15:11]);
    assign unused_ins_bits = ^{In_ins[25:21], In_ins[10:6]};

    wb_state_e       state_q, state_d;
    logic            we_q, we_d;
    logic [RW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            err_q, err_d;
    logic [DW-1:0]   ret_q, ret_d;
    logic [RW-1:0]   ld_rt_q, ld_rt_d;
    logic [OP_W-1:0] ld_op_q, ld_op_d;
    logic [1:0]      ld_addr_q, ld_addr_d;

    logic            dec_wr;
    logic [RW-1:0]   dec_dst;
    logic [DW-1:0]   dec_val;
    logic [DW-1:0]   align_data;
    logic            align_mis;

    wb_load_align u_align (
        .op_i       (ld_op_q),
        .addr_i     (ld_addr_q),
        .word_i     (Mem_rdata),
        .data_c     (align_data),
        .misalign_c (align_mis)
    );

    // Non-load destination and result source
    always_comb begin
        dec_wr  = 1'b0;
        dec_dst = ins_rt;
        dec_val = In_alu;
        if (ins_op == OP_R_FORM) begin
            dec_wr  = (ins_func != FN_JR);
            dec_dst = ins_rd;
            if (ins_func == FN_JALR) dec_val = In_pc4;
        end else if (is_alu_imm(ins_op)) begin
            dec_wr = 1'b1;
        end else if (ins_op == OP_JAL) begin
            dec_wr  = 1'b1;
            dec_dst = RW'(31);
            dec_val = In_pc4;
        end
    end

    // Next-state; Waddr/Wdata only move when a real write is issued
    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        ret_d     = ret_q;
        ld_rt_d   = ld_rt_q;
        ld_op_d   = ld_op_q;
        ld_addr_d = ld_addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (Mem_rvalid) err_d = 1'b1;
                if (In_valid) begin
                    if (is_load(ins_op)) begin
                        ld_rt_d   = ins_rt;
                        ld_op_d   = ins_op;
                        ld_addr_d = In_alu[1:0];
                        state_d   = ST_WAIT_MEM;
                    end else begin
                        ret_d = ret_q + DW'(1);
                        if (dec_wr && (dec_dst != '0)) begin
                            we_d    = 1'b1;
                            waddr_d = dec_dst;
                            wdata_d = dec_val;
                        end
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (Mem_rvalid) begin
                    state_d = ST_IDLE;
                    ret_d   = ret_q + DW'(1);
                    err_d   = err_q | align_mis;
                    if (ld_rt_q != '0) begin
                        we_d    = 1'b1;
                        waddr_d = ld_rt_q;
                        wdata_d = align_data;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            ret_q     <= '0;
            ld_rt_q   <= '0;
            ld_op_q   <= '0;
            ld_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            ret_q     <= ret_d;
            ld_rt_q   <= ld_rt_d;
            ld_op_q   <= ld_op_d;
            ld_addr_q <= ld_addr_d;
        end
    end

    assign In_ready = (state_q == ST_IDLE);
    assign Busy     = (state_q == ST_WAIT_MEM);
    assign We       = we_q;
    assign Waddr    = waddr_q;
    assign Wdata    = wdata_q;
    assign Err      = err_q;
    assign Ret_cnt  = ret_q;

endmodule

// File: tb/tb_mips_wb_stage.sv
// Self-checking bench for mips_wb_stage: directed cases plus randomized traffic
// against a behavioural model of the write-back rules.
module tb_mips_wb_stage;

    logic        CLK;
    logic        RST;
    logic        In_valid;
    logic        In_ready;
    logic [31:0] In_ins;
    logic [31:0] In_alu;
    logic [31:0] In_pc4;
    logic        Mem_rvalid;
    logic [31:0] Mem_rdata;
    logic        We;
    logic [4:0]  Waddr;
    logic [31:0] Wdata;
    logic        Busy;
    logic        Err;
    logic [31:0] Ret_cnt;

    mips_wb_stage #(.DW(32), .RW(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .In_valid   (In_valid),
        .In_ready   (In_ready),
        .In_ins     (In_ins),
        .In_alu     (In_alu),
        .In_pc4     (In_pc4),
        .Mem_rvalid (Mem_rvalid),
        .Mem_rdata  (Mem_rdata),
        .We         (We),
        .Waddr      (Waddr),
        .Wdata      (Wdata),
        .Busy       (Busy),
        .Err        (Err),
        .Ret_cnt    (Ret_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Model state: what the outputs must show after the most recent edge
    bit          m_wait;
    logic [4:0]  m_rt;
    logic [5:0]  m_op;
    logic [1:0]  m_addr;
    bit          m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_err;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [5:0] fn);
        return {op, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic bit is_ld(input logic [5:0] op);
        return op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
    endfunction

    function automatic void nonload_result(input logic [31:0] ins, input logic [31:0] alu,
                                           input logic [31:0] pc4, output bit wr,
                                           output logic [4:0] dst, output logic [31:0] val);
        logic [5:0] op;
        logic [5:0] fn;
        op  = ins[31:26];
        fn  = ins[5:0];
        wr  = 1'b0;
        dst = 5'd0;
        val = 32'd0;
        if (op == 6'h00) begin
            if (fn != 6'h08) begin
                wr  = 1'b1;
                dst = ins[15:11];
                val = (fn == 6'h09) ? pc4 : alu;
            end
        end else if (op >= 6'h08 && op <= 6'h0F) begin
            wr  = 1'b1;
            dst = ins[20:16];
            val = alu;
        end else if (op == 6'h03) begin
            wr  = 1'b1;
            dst = 5'd31;
            val = pc4;
        end
        if (dst == 5'd0) wr = 1'b0;
    endfunction

    // Load data by shifting/masking the word arithmetically
    function automatic void load_result(input logic [5:0] op, input logic [1:0] a,
                                        input logic [31:0] w, output logic [31:0] val,
                                        output bit mis);
        int unsigned b;
        int unsigned h;
        int unsigned sh_b;
        int unsigned sh_h;
        sh_b = 8 * int'(a);
        sh_h = (a >= 2'd2) ? 16 : 0;
        b    = (w >> sh_b) & 32'hFF;
        h    = (w >> sh_h) & 32'hFFFF;
        mis  = 1'b0;
        val  = w;
        case (op)
            6'h20: val = (b >= 128) ? b - 256 : b;
            6'h24: val = b;
            6'h21: begin val = (h >= 32768) ? h - 65536 : h; mis = (a == 2'd1 || a == 2'd3); end
            6'h25: begin val = h; mis = (a == 2'd1 || a == 2'd3); end
            6'h23: mis = (a != 2'd0);
            default: ;
        endcase
    endfunction

    task automatic model_reset();
        m_wait  = 1'b0;
        m_rt    = 5'd0;
        m_op    = 6'd0;
        m_addr  = 2'd0;
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
        m_err   = 1'b0;
        m_cnt   = 32'd0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                              input logic [31:0] pc4, input logic rv, input logic [31:0] rd);
        bit          wr;
        bit          mis;
        logic [4:0]  dst;
        logic [31:0] val;
        m_we = 1'b0;
        if (!m_wait) begin
            if (rv) m_err = 1'b1;
            if (v) begin
                if (is_ld(ins[31:26])) begin
                    m_wait = 1'b1;
                    m_rt   = ins[20:16];
                    m_op   = ins[31:26];
                    m_addr = alu[1:0];
                end else begin
                    m_cnt = m_cnt + 32'd1;
                    nonload_result(ins, alu, pc4, wr, dst, val);
                    if (wr) begin
                        m_we    = 1'b1;
                        m_waddr = dst;
                        m_wdata = val;
                    end
                end
            end
        end else if (rv) begin
            m_wait = 1'b0;
            m_cnt  = m_cnt + 32'd1;
            load_result(m_op, m_addr, rd, val, mis);
            if (mis) m_err = 1'b1;
            if (m_rt != 5'd0) begin
                m_we    = 1'b1;
                m_waddr = m_rt;
                m_wdata = val;
            end
        end
    endtask

    task automatic compare_all();
        chk("we",       32'(We),       32'(m_we));
        chk("waddr",    32'(Waddr),    32'(m_waddr));
        chk("wdata",    Wdata,         m_wdata);
        chk("busy",     32'(Busy),     32'(m_wait));
        chk("in_ready", 32'(In_ready), 32'(!m_wait));
        chk("err",      32'(Err),      32'(m_err));
        chk("ret_cnt",  Ret_cnt,       m_cnt);
    endtask

    // Called #1 after a rising edge; returns #1 after the next one
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic rv, input logic [31:0] rd);
        In_valid   = v;
        In_ins     = ins;
        In_alu     = alu;
        In_pc4     = pc4;
        Mem_rvalid = rv;
        Mem_rdata  = rd;
        model_step(v, ins, alu, pc4, rv, rd);
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    // Asynchronous reset asserted between edges
    task automatic reset_mid();
        RST        = 1'b1;
        In_valid   = 1'b0;
        Mem_rvalid = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        compare_all();
    endtask

    logic [5:0]  r_op;
    logic [5:0]  r_fn;
    logic        r_v;
    logic        r_rv;
    logic [31:0] r_ins;

    initial begin
        RST        = 1'b1;
        In_valid   = 1'b0;
        In_ins     = 32'd0;
        In_alu     = 32'd0;
        In_pc4     = 32'd0;
        Mem_rvalid = 1'b0;
        Mem_rdata  = 32'd0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        compare_all();
        chk("rst_in_ready", 32'(In_ready), 32'd1);
        chk("rst_ret_cnt",  Ret_cnt,       32'd0);

        // ADD rd=9
        cycle(1'b1, mk(6'h00, 5'd10, 5'd11, 5'd9, 6'h20), 32'h5, 32'h0, 1'b0, 32'h0);
        chk("add_we", 32'(We), 32'd1);
        chk("add_waddr", 32'(Waddr), 32'd9);
        chk("add_wdata", Wdata, 32'd5);
        chk("add_cnt", Ret_cnt, 32'd1);

        // ADDI then ORI back to back
        cycle(1'b1, mk(6'h08, 5'd1, 5'd8, 5'd0, 6'h00), 32'h10, 32'h0, 1'b0, 32'h0);
        chk("addi_we", 32'(We), 32'd1);
        chk("addi_waddr", 32'(Waddr), 32'd8);
        cycle(1'b1, mk(6'h0D, 5'd1, 5'd12, 5'd0, 6'h00), 32'hFF, 32'h0, 1'b0, 32'h0);
        chk("ori_we", 32'(We), 32'd1);
        chk("ori_waddr", 32'(Waddr), 32'd12);
        chk("ori_wdata", Wdata, 32'hFF);

        // LB then LBU from byte lane 3
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, mk((k == 0) ? 6'h20 : 6'h24, 5'd2, 5'd4, 5'd0, 6'h00),
                  32'h0000_1003, 32'h0, 1'b0, 32'h0);
            chk("ld_busy", 32'(Busy), 32'd1);
            chk("ld_ready", 32'(In_ready), 32'd0);
            cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
            chk("ld_busy2", 32'(Busy), 32'd1);
            cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h80FF_0000);
            chk("ld_we", 32'(We), 32'd1);
            chk("ld_waddr", 32'(Waddr), 32'd4);
            chk("ld_wdata", Wdata, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
        end

        // JAL, SW
        cycle(1'b1, mk(6'h03, 5'd0, 5'd0, 5'd0, 6'h00), 32'h1234, 32'h0040_0008, 1'b0, 32'h0);
        chk("jal_waddr", 32'(Waddr), 32'd31);
        chk("jal_wdata", Wdata, 32'h0040_0008);
        cycle(1'b1, mk(6'h2B, 5'd3, 5'd7, 5'd0, 6'h00), 32'h100, 32'h0, 1'b0, 32'h0);
        chk("sw_we", 32'(We), 32'd0);
        chk("sw_cnt", Ret_cnt, 32'd7);

        // ADD to $0, misaligned LW
        cycle(1'b1, mk(6'h00, 5'd1, 5'd2, 5'd0, 6'h20), 32'h77, 32'h0, 1'b0, 32'h0);
        chk("r0_we", 32'(We), 32'd0);
        cycle(1'b1, mk(6'h23, 5'd1, 5'd6, 5'd0, 6'h00), 32'h0000_2002, 32'h0, 1'b0, 32'h0);
        chk("lw_err_early", 32'(Err), 32'd0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("lw_err", 32'(Err), 32'd1);
        chk("lw_wdata", Wdata, 32'hDEAD_BEEF);
        chk("lw_cnt", Ret_cnt, 32'd9);

        // Stray response in IDLE
        reset_mid();
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h1);
        chk("stray_err", 32'(Err), 32'd1);
        chk("stray_we", 32'(We), 32'd0);

        // Reset while parked on a load; late response is stale
        reset_mid();
        cycle(1'b1, mk(6'h23, 5'd1, 5'd5, 5'd0, 6'h00), 32'h0, 32'h0, 1'b0, 32'h0);
        chk("park_busy", 32'(Busy), 32'd1);
        reset_mid();
        chk("rstw_ready", 32'(In_ready), 32'd1);
        chk("rstw_busy", 32'(Busy), 32'd0);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'hCAFE_0001);
        chk("stale_we", 32'(We), 32'd0);
        chk("stale_err", 32'(Err), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) reset_mid();
            case ($urandom_range(0, 9))
                0, 9: begin
                    r_op = 6'h00;
                    case ($urandom_range(0, 3))
                        0: r_fn = 6'h20;
                        1: r_fn = 6'h08;
                        2: r_fn = 6'h09;
                        default: r_fn = 6'($urandom_range(0, 63));
                    endcase
                end
                1: begin r_op = 6'($urandom_range(8, 15)); r_fn = 6'($urandom_range(0, 63)); end
                2: begin r_op = 6'h03; r_fn = 6'($urandom_range(0, 63)); end
                3: begin
                    case ($urandom_range(0, 5))
                        0: r_op = 6'h02;
                        1: r_op = 6'h04;
                        2: r_op = 6'h05;
                        3: r_op = 6'h28;
                        4: r_op = 6'h29;
                        default: r_op = 6'h2B;
                    endcase
                    r_fn = 6'($urandom_range(0, 63));
                end
                8: begin r_op = 6'($urandom_range(0, 63)); r_fn = 6'($urandom_range(0, 63)); end
                default: begin
                    case ($urandom_range(0, 4))
                        0: r_op = 6'h20;
                        1: r_op = 6'h21;
                        2: r_op = 6'h23;
                        3: r_op = 6'h24;
                        default: r_op = 6'h25;
                    endcase
                    r_fn = 6'($urandom_range(0, 63));
                end
            endcase
            r_ins = mk(r_op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)), r_fn);
            r_v   = ($urandom_range(0, 3) != 0);
            r_rv  = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
            cycle(r_v, r_ins, $urandom(), $urandom(), r_rv, $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
